// File: rtl/jellyvl_etherneco_pkg.sv
// jellyvl_etherneco_pkg: shared EtherNeco packet constants, sync payload layout and FSM states
package jellyvl_etherneco_pkg;

    localparam logic [7:0] PKT_TYPE_SYNC     = 8'h10;
    localparam logic [7:0] PKT_TYPE_RESPONSE = 8'h80;

    localparam int SYNC_PAYLOAD_LENGTH = 13;
    localparam int SYNC_OFS_FLAGS      = 0;
    localparam int SYNC_OFS_TIME       = 1;
    localparam int SYNC_OFS_DELAY      = 9;
    localparam int SYNC_OFS_END        = 13;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RESULT
    } sync_rx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/jellyvl_etherneco_payload_capture.sv
// jellyvl_etherneco_payload_capture: sync payload byte counter and little-endian field assembler (delay field kept only with JELLYVL_ETHERNECO_SYNCTIMER_DELAY_EN)
module jellyvl_etherneco_payload_capture
    import jellyvl_etherneco_pkg::*;
#(
    parameter int PAYLOAD_LENGTH = SYNC_PAYLOAD_LENGTH
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    input  logic        s_first,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic [3:0]  count_next,
    output logic        bad_next,
    output logic [7:0]  flags,
    output logic [63:0] time_field,
    output logic [31:0] delay_field
);

    logic [3:0] count;
    logic       bad;
    logic       byte_en;
    logic [2:0] time_sel;

    assign byte_en  = enable && s_valid && !clear;
    assign time_sel = 3'(count - 4'(SYNC_OFS_TIME));

    // next count/bad are exported so a byte arriving with rx_end is seen by the accept check
    always_comb begin
        count_next = clear ? 4'd0 : (byte_en && count != 4'hF) ? count + 4'd1 : count;
        bad_next   = clear ? 1'b0 : bad || (byte_en && ((s_first && count != 4'd0) || 32'(count) >= PAYLOAD_LENGTH));
    end

    // byte counter and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
            bad   <= 1'b0;
        end else begin
            count <= count_next;
            bad   <= bad_next;
        end
    end

    // flags byte and little-endian master time assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            flags      <= 8'd0;
            time_field <= 64'd0;
        end else if (byte_en) begin
            if (count == 4'(SYNC_OFS_FLAGS)) flags <= s_data;
            if (count >= 4'(SYNC_OFS_TIME) && count < 4'(SYNC_OFS_DELAY)) time_field[{time_sel, 3'b000} +: 8] <= s_data;
        end
    end

`ifdef JELLYVL_ETHERNECO_SYNCTIMER_DELAY_EN
    logic [1:0] delay_sel;
    assign delay_sel = 2'(count - 4'(SYNC_OFS_DELAY));

    // little-endian delay field assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_field <= 32'd0;
        end else if (byte_en && count >= 4'(SYNC_OFS_DELAY) && count < 4'(SYNC_OFS_END)) begin
            delay_field[{delay_sel, 3'b000} +: 8] <= s_data;
        end
    end
`else
    assign delay_field = 32'd0;
`endif

endmodule

// File: rtl/jellyvl_etherneco_synctimer_slave_rx.sv
// jellyvl_etherneco_synctimer_slave_rx: time-sync packet receiver producing master/local time and error (delay field added with JELLYVL_ETHERNECO_SYNCTIMER_DELAY_EN)
module jellyvl_etherneco_synctimer_slave_rx
    import jellyvl_etherneco_pkg::*;
#(
    parameter int                     TIMER_WIDTH    = 64,
    parameter logic [7:0]             SYNC_TYPE      = PKT_TYPE_SYNC,
    parameter int                     PAYLOAD_LENGTH = SYNC_PAYLOAD_LENGTH,
    parameter logic [TIMER_WIDTH-1:0] RX_LATENCY     = '0
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic [TIMER_WIDTH-1:0] current_time,
    input  logic                   rx_start,
    input  logic                   rx_end,
    input  logic                   rx_error,
    input  logic [15:0]            rx_length,
    input  logic [7:0]             rx_type,
    input  logic [7:0]             rx_node,
    input  logic                   s_first,
    input  logic                   s_last,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   sync_valid,
    output logic                   sync_override,
    output logic [7:0]             sync_node,
    output logic [TIMER_WIDTH-1:0] sync_master_time,
    output logic [TIMER_WIDTH-1:0] sync_local_time,
    output logic [TIMER_WIDTH-1:0] sync_time_error,
    output logic [15:0]            drop_count
);

    sync_rx_state_t         state;
    logic [TIMER_WIDTH-1:0] local_time;
    logic [7:0]             node;
    logic [15:0]            length;
    logic [3:0]             count_next;
    logic                   bad_next;
    logic [7:0]             flags;
    logic [63:0]            time_field;
    logic [TIMER_WIDTH-1:0] master_calc;
    logic                   start_hit;
    logic                   restart;
    logic                   accept;

    assign start_hit = rx_start && rx_type == SYNC_TYPE;
    assign restart   = start_hit && (state != CAPTURE || !(rx_end || rx_error));
    assign accept    = !bad_next && length == 16'(PAYLOAD_LENGTH - 1) && count_next == 4'(PAYLOAD_LENGTH);

`ifdef JELLYVL_ETHERNECO_SYNCTIMER_DELAY_EN
    logic [31:0] delay_field;
    assign master_calc = time_field[TIMER_WIDTH-1:0] + RX_LATENCY + TIMER_WIDTH'(delay_field);
`else
    assign master_calc = time_field[TIMER_WIDTH-1:0] + RX_LATENCY;
`endif

    jellyvl_etherneco_payload_capture #(
        .PAYLOAD_LENGTH(PAYLOAD_LENGTH)
    ) u_capture (
        .reset      (reset),
        .clk        (clk),
        .clear      (restart),
        .enable     (state == CAPTURE),
        .s_first    (s_first),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .count_next (count_next),
        .bad_next   (bad_next),
        .flags      (flags),
        .time_field (time_field),
`ifdef JELLYVL_ETHERNECO_SYNCTIMER_DELAY_EN
        .delay_field(delay_field)
`else
        .delay_field()
`endif
    );

    // packet FSM with header latching, drop counting and registered sync result
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            local_time       <= '0;
            node             <= 8'd0;
            length           <= 16'd0;
            drop_count       <= 16'd0;
            sync_valid       <= 1'b0;
            sync_override    <= 1'b0;
            sync_node        <= 8'd0;
            sync_master_time <= '0;
            sync_local_time  <= '0;
            sync_time_error  <= '0;
        end else begin
            sync_valid <= 1'b0;
            if (restart) begin
                local_time <= current_time;
                node       <= rx_node;
                length     <= rx_length;
            end
            case (state)
                IDLE: state <= start_hit ? CAPTURE : IDLE;
                CAPTURE: begin
                    if (rx_error) begin
                        drop_count <= sat_inc16(drop_count);
                        state      <= IDLE;
                    end else if (rx_end) begin
                        if (!accept) drop_count <= sat_inc16(drop_count);
                        state <= accept ? RESULT : IDLE;
                    end else if (rx_start) begin
                        drop_count <= sat_inc16(drop_count);
                        state      <= start_hit ? CAPTURE : IDLE;
                    end
                end
                RESULT: begin
                    sync_valid       <= 1'b1;
                    sync_override    <= flags[0];
                    sync_node        <= node;
                    sync_master_time <= master_calc;
                    sync_local_time  <= local_time;
                    sync_time_error  <= master_calc - local_time;
                    state            <= start_hit ? CAPTURE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave_rx.sv
// tb_jellyvl_etherneco_synctimer_slave_rx: table-driven and scoreboard bench for the sync slave receiver
module tb_jellyvl_etherneco_synctimer_slave_rx;

    logic        reset = 1'b1;
    logic        clk = 1'b0;
    logic [63:0] current_time = 64'd0;
    logic        rx_start = 1'b0;
    logic        rx_end = 1'b0;
    logic        rx_error = 1'b0;
    logic [15:0] rx_length = 16'd0;
    logic [7:0]  rx_type = 8'd0;
    logic [7:0]  rx_node = 8'd0;
    logic        s_first = 1'b0;
    logic        s_last = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        sync_valid;
    logic        sync_override;
    logic [7:0]  sync_node;
    logic [63:0] sync_master_time;
    logic [63:0] sync_local_time;
    logic [63:0] sync_time_error;
    logic [15:0] drop_count;

    jellyvl_etherneco_synctimer_slave_rx dut (
        .reset           (reset),
        .clk             (clk),
        .current_time    (current_time),
        .rx_start        (rx_start),
        .rx_end          (rx_end),
        .rx_error        (rx_error),
        .rx_length       (rx_length),
        .rx_type         (rx_type),
        .rx_node         (rx_node),
        .s_first         (s_first),
        .s_last          (s_last),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .sync_valid      (sync_valid),
        .sync_override   (sync_override),
        .sync_node       (sync_node),
        .sync_master_time(sync_master_time),
        .sync_local_time (sync_local_time),
        .sync_time_error (sync_time_error),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  typ;
        logic [15:0] len;
        int          nbytes;
        int          abort_at;
        bit          end_last;
        logic [7:0]  flags;
        logic [63:0] mt;
        logic [31:0] dly;
        logic [63:0] lt;
        bit          ok;
        bit          drop;
        logic [63:0] err_nd;
    } vec_t;

    typedef struct {
        logic [63:0] master;
        logic [63:0] local_t;
        logic [63:0] err;
        logic        ovr;
        logic [7:0]  node;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pulses = 0;

`ifdef JELLYVL_ETHERNECO_SYNCTIMER_DELAY_EN
    localparam bit DELAY_EN = 1'b1;
`else
    localparam bit DELAY_EN = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int i, input logic [7:0] f, input logic [63:0] mt, input logic [31:0] d);
        if (i == 0) return f;
        if (i <= 8) return mt[8*(i-1) +: 8];
        if (i <= 12) return d[8*(i-9) +: 8];
        return 8'hAA;
    endfunction

    always @(negedge clk) begin
        if (sync_valid) begin
            n_pulses++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sync: got sync_valid at cycle %0d required none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("master_time", sync_master_time, e.master);
                chk("local_time", sync_local_time, e.local_t);
                chk("time_error", sync_time_error, e.err);
                chk("override", 64'(sync_override), 64'(e.ovr));
                chk("node", 64'(sync_node), 64'(e.node));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input vec_t v, input logic [7:0] node, output int end_cyc);
        bit aborted = 1'b0;
        step();
        rx_start = 1'b1; rx_type = v.typ; rx_length = v.len; rx_node = node; current_time = v.lt;
        step();
        rx_start = 1'b0; current_time = v.lt + 64'h99;
        end_cyc = 0;
        for (int i = 0; i < v.nbytes; i++) begin
            if (i == v.abort_at) begin
                s_valid = 1'b0; rx_error = 1'b1;
                step();
                rx_error = 1'b0;
                aborted = 1'b1;
                break;
            end
            s_valid = 1'b1; s_first = (i == 0); s_last = (i == v.nbytes - 1);
            s_data = pbyte(i, v.flags, v.mt, v.dly);
            rx_end = v.end_last && (i == v.nbytes - 1);
            if (rx_end) end_cyc = cyc;
            step();
            s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; rx_end = 1'b0;
        end
        if (!aborted && !v.end_last) begin
            rx_end = 1'b1; end_cyc = cyc;
            step();
            rx_end = 1'b0;
        end
    endtask

    vec_t vecs[9];

    initial begin
        int   end_cyc;
        int   exp_drop;
        exp_t e;
        vecs[0] = '{8'h10, 16'd12, 13, -1, 1'b0, 8'h01, 64'h0000_0001_0000_0000, 32'h20, 64'h0000_0000_FFFF_FF00, 1'b1, 1'b0, 64'h100};
        vecs[1] = '{8'h10, 16'd12, 12, -1, 1'b0, 8'h01, 64'h1234, 32'h0, 64'h10, 1'b0, 1'b1, 64'h0};
        vecs[2] = '{8'h10, 16'd12, 13, 5, 1'b0, 8'h01, 64'h5555, 32'h0, 64'h10, 1'b0, 1'b1, 64'h0};
        vecs[3] = '{8'h10, 16'd12, 13, -1, 1'b0, 8'hFE, 64'h1234_5678_9ABC_DEF0, 32'h5, 64'h1000, 1'b1, 1'b0, 64'h1234_5678_9ABC_CEF0};
        vecs[4] = '{8'h20, 16'd12, 13, -1, 1'b0, 8'h01, 64'h77, 32'h0, 64'h10, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{8'h10, 16'd12, 13, -1, 1'b0, 8'h03, 64'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 64'h10};
        vecs[6] = '{8'h10, 16'd11, 13, -1, 1'b0, 8'h01, 64'h99, 32'h0, 64'h10, 1'b0, 1'b1, 64'h0};
        vecs[7] = '{8'h10, 16'd12, 14, -1, 1'b0, 8'h01, 64'h99, 32'h0, 64'h10, 1'b0, 1'b1, 64'h0};
        vecs[8] = '{8'h10, 16'd12, 13, -1, 1'b1, 8'h00, 64'h50, 32'h3, 64'h40, 1'b1, 1'b0, 64'h10};
        exp_drop = 0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_valid", 64'(sync_valid), 64'd0);
        chk("reset_master", sync_master_time, 64'd0);
        chk("reset_error", sync_time_error, 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 9; i++) begin
            send_pkt(vecs[i], 8'(i + 1), end_cyc);
            if (vecs[i].ok) begin
                e.master  = vecs[i].mt + (DELAY_EN ? 64'(vecs[i].dly) : 64'd0);
                e.local_t = vecs[i].lt;
                e.err     = vecs[i].err_nd + (DELAY_EN ? 64'(vecs[i].dly) : 64'd0);
                e.ovr     = vecs[i].flags[0];
                e.node    = 8'(i + 1);
                e.cyc     = end_cyc + 2;
                q.push_back(e);
            end
            if (vecs[i].drop) exp_drop++;
            repeat (3) step();
            chk($sformatf("drop_count_vec%0d", i), 64'(drop_count), 64'(exp_drop));
        end
        chk("hold_master", sync_master_time, 64'h50 + (DELAY_EN ? 64'd3 : 64'd0));
        rx_start = 1'b1; rx_type = 8'h10; rx_length = 16'd12;
        repeat (65545) step();
        rx_start = 1'b0;
        step();
        chk("drop_saturate", 64'(drop_count), 64'hFFFF);
        rx_error = 1'b1;
        step();
        rx_error = 1'b0;
        step();
        chk("drop_saturate_hold", 64'(drop_count), 64'hFFFF);
        step();
        rx_start = 1'b1; rx_type = 8'h10; rx_length = 16'd12; rx_node = 8'h42; current_time = 64'h500;
        step();
        rx_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; s_first = (i == 0); s_data = pbyte(i, 8'h01, 64'h1000, 32'h0);
            step();
        end
        s_valid = 1'b0; s_first = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_valid", 64'(sync_valid), 64'd0);
        chk("midreset_master", sync_master_time, 64'd0);
        chk("midreset_local", sync_local_time, 64'd0);
        chk("midreset_node", 64'(sync_node), 64'd0);
        chk("midreset_drop", 64'(drop_count), 64'd0);
        n_pulses = 0;
        for (int i = 6; i < 13; i++) begin
            s_valid = 1'b1; s_data = pbyte(i, 8'h01, 64'h1000, 32'h0); s_last = (i == 12); rx_end = (i == 12);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0; rx_end = 1'b0;
        repeat (6) step();
        chk("midreset_no_pulse", 64'(n_pulses), 64'd0);
        chk("midreset_no_drop", 64'(drop_count), 64'd0);
        repeat (10) step();
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
